// File: rtl/trace_pkg.sv
// Shared types for the pipeline trace buffer: capture FSM encoding and entry sizing.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_CAPTURING = 2'd2,
        ST_STOPPED   = 2'd3
    } trace_state_e;

    // One trace entry is {PC, writeback data, cycle stamp}.
    function automatic int entry_width(input int data_w, input int cnt_w);
        return 2 * data_w + cnt_w;
    endfunction

    localparam int ENTRY_WIDTH = entry_width(32, 16);

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; a push is visible at dat_o one cycle later.
// A push while full is refused unless a pop happens in the same cycle; pop while empty is ignored.
module trace_fifo #(
    parameter int WIDTH      = 80,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      dat_i,
    output logic [WIDTH-1:0]      dat_o,
    output logic                  full_o,
    output logic                  full_nxt_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic                push_ok;
    logic                pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign full_o     = (count_o == DEPTH_C);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign pop_ok     = pop_i & ~empty_o;
    assign push_ok    = push_i & (~full_o | pop_ok);
    assign full_nxt_o = ((wr_ptr_d - rd_ptr_d) == DEPTH_C);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= dat_i;
    end

    assign dat_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Triggered PC-change trace capture into a FIFO, drained over valid/ready; entries appear 1 cycle after capture.
// Consumer stalls fill the FIFO: capture then stops (STOP_ON_FULL=1) or drops and counts overflows (0).
module pipeline_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int CNT_WIDTH    = 16,
    parameter bit STOP_ON_FULL = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] PC_In,
    input  logic [DATA_WIDTH-1:0] WriteData_In,
    input  logic                  Arm,
    input  logic                  Stop,
    input  logic [DATA_WIDTH-1:0] Trigger_PC,
    output logic                  Trace_Valid,
    input  logic                  Trace_Ready,
    output logic [DATA_WIDTH-1:0] Trace_PC,
    output logic [DATA_WIDTH-1:0] Trace_Data,
    output logic [CNT_WIDTH-1:0]  Trace_Cycle,
    output logic [ADDR_WIDTH:0]   Count,
    output logic [15:0]           Overflow_Cnt,
    output logic [1:0]            State_Out
);

    localparam int ENTRY_W = entry_width(DATA_WIDTH, CNT_WIDTH);

    trace_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0]  cyc_q, cyc_d;
    logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;
    logic                  last_vld_q, last_vld_d;
    logic [15:0]           ovf_q, ovf_d;

    logic                  trig_hit;
    logic                  pc_new;
    logic                  push;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_full_nxt;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    head_dat;

    assign trig_hit = (state_q == ST_ARMED) && (PC_In == Trigger_PC);
    assign pc_new   = !last_vld_q || (PC_In != last_pc_q);
    assign push     = ((state_q == ST_CAPTURING) || trig_hit) && pc_new;
    assign drop     = push & fifo_full & ~(Trace_Ready & ~fifo_empty);

    always_comb begin
        state_d = state_q;
        if (Arm) begin
            state_d = ST_ARMED;
        end else if (Stop) begin
            state_d = ST_STOPPED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (trig_hit) state_d = (STOP_ON_FULL && fifo_full_nxt) ? ST_STOPPED : ST_CAPTURING;
                end
                // Leave as the last slot fills so no later capture can be dropped.
                ST_CAPTURING: begin
                    if (STOP_ON_FULL && fifo_full_nxt) state_d = ST_STOPPED;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cyc_d      = cyc_q + 1'b1;
        last_pc_d  = last_pc_q;
        last_vld_d = last_vld_q;
        ovf_d      = ovf_q;
        if (Arm) begin
            last_vld_d = 1'b0;
            ovf_d      = '0;
        end else begin
            if (push) begin
                last_pc_d  = PC_In;
                last_vld_d = 1'b1;
            end
            if (drop && !STOP_ON_FULL && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            last_pc_q  <= last_pc_d;
            last_vld_q <= last_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    trace_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .clr_i      (Arm),
        .push_i     (push),
        .pop_i      (Trace_Ready),
        .dat_i      ({PC_In, WriteData_In, cyc_q}),
        .dat_o      (head_dat),
        .full_o     (fifo_full),
        .full_nxt_o (fifo_full_nxt),
        .empty_o    (fifo_empty),
        .count_o    (Count)
    );

    assign Trace_Valid                         = ~fifo_empty;
    assign {Trace_PC, Trace_Data, Trace_Cycle} = head_dat;
    assign Overflow_Cnt                        = ovf_q;
    assign State_Out                           = state_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench for pipeline_trace_buffer: one stop-on-full and one drop-on-full instance share all inputs.
module tb_pipeline_trace_buffer;

    logic        Clock = 1'b0;
    logic        Reset, Arm, Stop, Trace_Ready;
    logic [31:0] PC_In, WriteData_In, Trigger_PC;

    logic        tv   [2];
    logic [31:0] tpc  [2];
    logic [31:0] tdat [2];
    logic [15:0] tcyc [2];
    logic [4:0]  tcnt [2];
    logic [15:0] tovf [2];
    logic [1:0]  tst  [2];

    always #5 Clock = ~Clock;

    pipeline_trace_buffer #(.STOP_ON_FULL(1'b1)) u_sof (
        .Clock(Clock), .Reset(Reset), .PC_In(PC_In), .WriteData_In(WriteData_In),
        .Arm(Arm), .Stop(Stop), .Trigger_PC(Trigger_PC),
        .Trace_Valid(tv[0]), .Trace_Ready(Trace_Ready), .Trace_PC(tpc[0]),
        .Trace_Data(tdat[0]), .Trace_Cycle(tcyc[0]), .Count(tcnt[0]),
        .Overflow_Cnt(tovf[0]), .State_Out(tst[0])
    );

    pipeline_trace_buffer #(.STOP_ON_FULL(1'b0)) u_drop (
        .Clock(Clock), .Reset(Reset), .PC_In(PC_In), .WriteData_In(WriteData_In),
        .Arm(Arm), .Stop(Stop), .Trigger_PC(Trigger_PC),
        .Trace_Valid(tv[1]), .Trace_Ready(Trace_Ready), .Trace_PC(tpc[1]),
        .Trace_Data(tdat[1]), .Trace_Cycle(tcyc[1]), .Count(tcnt[1]),
        .Overflow_Cnt(tovf[1]), .State_Out(tst[1])
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
        logic [15:0] cyc;
    } ent_t;

    // Reference model: a queue of entries per instance plus a state number 0..3.
    ent_t        mq [2][$];
    int          m_st  [2];
    logic [31:0] m_last[2];
    bit          m_lv  [2];
    int          m_ovf [2];
    logic [15:0] m_cyc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit sof;
            bit match;
            bit cap;
            sof = (k == 0);
            if (Reset) begin
                mq[k].delete();
                m_st[k]  = 0;
                m_lv[k]  = 1'b0;
                m_ovf[k] = 0;
            end else begin
                match = (m_st[k] == 1) && (PC_In == Trigger_PC);
                cap   = (m_st[k] == 2 || match) && (!m_lv[k] || PC_In != m_last[k]);
                if (Arm) begin
                    mq[k].delete();
                    m_ovf[k] = 0;
                    m_lv[k]  = 1'b0;
                    m_st[k]  = 1;
                end else begin
                    if (Trace_Ready && mq[k].size() > 0) void'(mq[k].pop_front());
                    if (cap) begin
                        if (mq[k].size() < 16) mq[k].push_back({PC_In, WriteData_In, m_cyc});
                        else if (!sof && m_ovf[k] < 65535) m_ovf[k]++;
                        m_last[k] = PC_In;
                        m_lv[k]   = 1'b1;
                    end
                    if (Stop) m_st[k] = 3;
                    else if (match) m_st[k] = 2;
                    if (sof && m_st[k] == 2 && mq[k].size() == 16) m_st[k] = 3;
                end
            end
        end
        m_cyc = Reset ? 16'd0 : m_cyc + 16'd1;
    endtask

    task automatic compare_model();
        for (int k = 0; k < 2; k++) begin
            ent_t h;
            h = (mq[k].size() > 0) ? mq[k][0] : '0;
            chk($sformatf("m%0d_valid", k), 64'(tv[k]), 64'(mq[k].size() > 0));
            chk($sformatf("m%0d_pc", k), 64'(tpc[k]), 64'(h.pc));
            chk($sformatf("m%0d_data", k), 64'(tdat[k]), 64'(h.dat));
            chk($sformatf("m%0d_cycle", k), 64'(tcyc[k]), 64'(h.cyc));
            chk($sformatf("m%0d_count", k), 64'(tcnt[k]), 64'(mq[k].size()));
            chk($sformatf("m%0d_ovf", k), 64'(tovf[k]), 64'(m_ovf[k]));
            chk($sformatf("m%0d_state", k), 64'(tst[k]), 64'(m_st[k]));
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        compare_model();
    endtask

    typedef struct {
        bit          arm;
        bit          stop;
        bit          rdy;
        logic [31:0] pc;
        int          st;
        int          cnt;
        bit          vld;
        logic [31:0] hpc;
        logic [15:0] hcyc;
    } vec_t;

    localparam logic [31:0] DMASK = 32'hA5A5_0000;

    vec_t tbl [18];
    int   rdy_bias;

    initial begin
        //          arm   stop  rdy   pc        st cnt vld   head pc   head cycle
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h38, 1, 0, 1'b0, 32'h00, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h38, 1, 0, 1'b0, 32'h00, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h3C, 1, 0, 1'b0, 32'h00, 16'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h40, 2, 1, 1'b1, 32'h40, 16'd3};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h44, 2, 2, 1'b1, 32'h40, 16'd3};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h44, 2, 2, 1'b1, 32'h40, 16'd3};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h50, 2, 3, 1'b1, 32'h40, 16'd3};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h50, 2, 3, 1'b1, 32'h40, 16'd3};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h50, 2, 3, 1'b1, 32'h40, 16'd3};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h54, 2, 4, 1'b1, 32'h40, 16'd3};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h54, 2, 3, 1'b1, 32'h44, 16'd4};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h54, 3, 2, 1'b1, 32'h50, 16'd6};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h60, 3, 1, 1'b1, 32'h54, 16'd9};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h60, 3, 0, 1'b0, 32'h00, 16'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h70, 3, 0, 1'b0, 32'h00, 16'd0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 32'h70, 1, 0, 1'b0, 32'h00, 16'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h40, 2, 1, 1'b1, 32'h40, 16'd16};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h40, 2, 1, 1'b1, 32'h40, 16'd16};

        Reset = 1'b1; Arm = 1'b0; Stop = 1'b0; Trace_Ready = 1'b0;
        PC_In = 32'h0; WriteData_In = 32'h0; Trigger_PC = 32'h40;
        m_cyc = 16'd0;

        // Reset held two cycles while the PC keeps moving.
        cyc();
        PC_In = 32'h40;
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_state", k), 64'(tst[k]), 64'd0);
            chk($sformatf("rst%0d_count", k), 64'(tcnt[k]), 64'd0);
            chk($sformatf("rst%0d_valid", k), 64'(tv[k]), 64'd0);
            chk($sformatf("rst%0d_pc", k), 64'(tpc[k]), 64'd0);
            chk($sformatf("rst%0d_data", k), 64'(tdat[k]), 64'd0);
            chk($sformatf("rst%0d_cycle", k), 64'(tcyc[k]), 64'd0);
            chk($sformatf("rst%0d_ovf", k), 64'(tovf[k]), 64'd0);
        end

        // Trigger, change detect, drain, stop and empty push+pop.
        Reset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            Arm          = tbl[i].arm;
            Stop         = tbl[i].stop;
            Trace_Ready  = tbl[i].rdy;
            PC_In        = tbl[i].pc;
            WriteData_In = tbl[i].pc ^ DMASK;
            cyc();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("tbl%0d_%0d_state", i, k), 64'(tst[k]), 64'(tbl[i].st));
                chk($sformatf("tbl%0d_%0d_count", i, k), 64'(tcnt[k]), 64'(tbl[i].cnt));
                chk($sformatf("tbl%0d_%0d_valid", i, k), 64'(tv[k]), 64'(tbl[i].vld));
                chk($sformatf("tbl%0d_%0d_pc", i, k), 64'(tpc[k]), 64'(tbl[i].hpc));
                chk($sformatf("tbl%0d_%0d_data", i, k), 64'(tdat[k]),
                    64'(tbl[i].vld ? (tbl[i].hpc ^ DMASK) : 32'h0));
                chk($sformatf("tbl%0d_%0d_cycle", i, k), 64'(tcyc[k]), 64'(tbl[i].hcyc));
            end
        end

        // Fill with 20 distinct PCs while the consumer stalls.
        Arm = 1'b1; Stop = 1'b0; Trace_Ready = 1'b0; Trigger_PC = 32'h100; PC_In = 32'hFC;
        cyc();
        Arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            PC_In        = 32'h100 + 32'(4 * i);
            WriteData_In = $urandom;
            cyc();
        end
        chk("full_sof_count", 64'(tcnt[0]), 64'd16);
        chk("full_sof_state", 64'(tst[0]), 64'd3);
        chk("full_sof_ovf", 64'(tovf[0]), 64'd0);
        chk("full_drop_count", 64'(tcnt[1]), 64'd16);
        chk("full_drop_ovf", 64'(tovf[1]), 64'd4);
        chk("full_drop_state", 64'(tst[1]), 64'd2);
        chk("full_drop_head", 64'(tpc[1]), 64'h100);

        // Push and pop together on a full FIFO.
        Trace_Ready = 1'b1; PC_In = 32'h200; WriteData_In = $urandom;
        cyc();
        chk("pp_drop_count", 64'(tcnt[1]), 64'd16);
        chk("pp_drop_head", 64'(tpc[1]), 64'h104);
        chk("pp_drop_ovf", 64'(tovf[1]), 64'd4);
        chk("pp_sof_count", 64'(tcnt[0]), 64'd15);

        for (int j = 0; j < 5; j++) begin
            cyc();
            chk($sformatf("drain%0d_drop_pc", j), 64'(tpc[1]), 64'(32'h108 + 32'(4 * j)));
            chk($sformatf("drain%0d_sof_pc", j), 64'(tpc[0]), 64'(32'h108 + 32'(4 * j)));
            chk($sformatf("drain%0d_drop_count", j), 64'(tcnt[1]), 64'(15 - j));
        end

        // Arm in the middle of a drain empties both FIFOs.
        Arm = 1'b1;
        cyc();
        Arm = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rearm%0d_count", k), 64'(tcnt[k]), 64'd0);
            chk($sformatf("rearm%0d_valid", k), 64'(tv[k]), 64'd0);
            chk($sformatf("rearm%0d_state", k), 64'(tst[k]), 64'd1);
            chk($sformatf("rearm%0d_ovf", k), 64'(tovf[k]), 64'd0);
        end

        // Random traffic against the queue model.
        Trigger_PC = 32'h48;
        rdy_bias   = 1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 256 == 0) rdy_bias = $urandom_range(0, 4);
            Reset        = ($urandom_range(0, 299) == 0);
            Arm          = ($urandom_range(0, 39) == 0);
            Stop         = ($urandom_range(0, 59) == 0);
            Trace_Ready  = ($urandom_range(0, 3) < rdy_bias);
            if ($urandom_range(0, 1) == 0) PC_In = 32'h40 + 32'(4 * $urandom_range(0, 7));
            WriteData_In = $urandom;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
